// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the fetch -> decode instruction buffer.
//   fetch_entry_t    : one buffered instruction {pc, instrux} at the default widths
//   fq_state_e       : occupancy-derived queue state (EMPTY / PARTIAL / FULL)
//   FQ_DEFAULT_DEPTH : default number of queue entries
//   NOP_INSTR        : canonical NOP encoding. It is reserved for future bubble
//                      insertion. Bubbles are currently presented as an all-zero word.
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int FQ_DEFAULT_DEPTH = 4;
    localparam int FQ_PC_WIDTH      = 64;
    localparam int FQ_INSTR_WIDTH   = 32;

    localparam logic [FQ_INSTR_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [FQ_PC_WIDTH-1:0]    pc;
        logic [FQ_INSTR_WIDTH-1:0] instrux;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        FQ_EMPTY   = 2'd0,
        FQ_PARTIAL = 2'd1,
        FQ_FULL    = 2'd2
    } fq_state_e;

endpackage

// File: rtl/fetch_queue_ram.sv
// -----------------------------------------------------------------------------
// fetch_queue_ram
// DEPTH-entry register array. It has one synchronous write port and one
// asynchronous read port. Entry contents are not reset: the queue pointers
// alone decide which entries are live.
//   clk     : rising-edge clock
//   i_we    : write enable
//   i_waddr : write index
//   i_wdata : entry to store
//   i_raddr : read index
//   o_rdata : entry at i_raddr (combinational)
// -----------------------------------------------------------------------------
module fetch_queue_ram
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = FQ_DEFAULT_DEPTH,
    parameter type entry_t = fetch_entry_t,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  entry_t        i_wdata,
    input  logic [AW-1:0] i_raddr,
    output entry_t        o_rdata
);

    entry_t r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Instruction buffer between the fetch and decode stages. It absorbs icache
// latency jitter and decode back-pressure, and it delivers instructions in
// program order. A taken-branch flush discards every buffered entry.
//
// Optional build macro: FETCH_QUEUE_BYPASS_EN. When this macro is defined, an
// instruction that arrives at an empty queue is shown on the outputs in the
// same cycle. If decode is not stalled, that instruction is consumed there and
// never stored.
//
// Handshake: an entry transfers on the fetch side when in_valid && in_ready &&
// !flush at a rising edge. It transfers on the decode side when
// out_valid && !deq_stall && !flush. in_ready depends on registered state only.
// A full queue therefore refuses input even in a cycle where it is being
// drained.
//
// Ports
//   clk, reset          : clock; synchronous active-low reset
//   in_valid/in_pc/in_instrux/in_ready : fetch side
//   flush               : taken-branch redirect, drops all contents
//   deq_stall           : decode cannot consume this cycle
//   out_valid/out_pc/out_instrux       : decode side (zeros when not valid)
//   occupancy           : number of stored entries
//   o_dbg_state         : occupancy-derived state, exposed for observation
// -----------------------------------------------------------------------------
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH       = FQ_DEFAULT_DEPTH,
    parameter int PC_WIDTH    = 64,
    parameter int INSTR_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [PC_WIDTH-1:0]      in_pc,
    input  logic [INSTR_WIDTH-1:0]   in_instrux,
    output logic                     in_ready,
    input  logic                     flush,
    input  logic                     deq_stall,
    output logic                     out_valid,
    output logic [PC_WIDTH-1:0]      out_pc,
    output logic [INSTR_WIDTH-1:0]   out_instrux,
    output logic [$clog2(DEPTH):0]   occupancy,
    output fq_state_e                o_dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef struct packed {
        logic [PC_WIDTH-1:0]    pc;
        logic [INSTR_WIDTH-1:0] instrux;
    } entry_t;

    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    fq_state_e     r_state;
    fq_state_e     w_state_next;
    logic [PW-1:0] w_occ_next;
    logic          w_empty;
    logic          w_full;
    logic          w_enq;
    logic          w_deq;
    entry_t        w_head;
    entry_t        w_wdata;

    // The MSB of each pointer is a wrap bit. Equal index bits mean the queue
    // is empty when the wrap bits match, and full when they differ.
    assign w_empty = (r_rd_ptr == r_wr_ptr);
    assign w_full  = (r_rd_ptr[AW-1:0] == r_wr_ptr[AW-1:0]) &&
                     (r_rd_ptr[AW] != r_wr_ptr[AW]);

    assign in_ready  = !w_full;
    assign occupancy = r_wr_ptr - r_rd_ptr;
    assign w_deq     = !w_empty && !deq_stall && !flush;

`ifdef FETCH_QUEUE_BYPASS_EN
    logic w_bypass;
    // The reset term stops a reset cycle from showing a bypassed instruction.
    assign w_bypass = w_empty && in_valid && !flush && reset;
    // A bypassed instruction that decode consumes immediately is not stored.
    assign w_enq    = in_valid && !w_full && !flush && !(w_bypass && !deq_stall);
`else
    assign w_enq    = in_valid && !w_full && !flush;
`endif

    assign w_wdata = '{pc: in_pc, instrux: in_instrux};

    fetch_queue_ram #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_enq),
        .i_waddr (r_wr_ptr[AW-1:0]),
        .i_wdata (w_wdata),
        .i_raddr (r_rd_ptr[AW-1:0]),
        .o_rdata (w_head)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            if (w_enq) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_deq) r_rd_ptr <= r_rd_ptr + PW'(1);
        end
    end

    // The state tracks occupancy. It is not used for control. It is kept as a
    // registered view so observers can follow queue-level transitions.
    always_ff @(posedge clk) begin
        if (!reset) r_state <= FQ_EMPTY;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_occ_next   = occupancy;
        w_state_next = FQ_PARTIAL;
        if (w_enq) w_occ_next = w_occ_next + PW'(1);
        if (w_deq) w_occ_next = w_occ_next - PW'(1);
        if (flush)                          w_state_next = FQ_EMPTY;
        else if (w_occ_next == '0)          w_state_next = FQ_EMPTY;
        else if (w_occ_next == PW'(DEPTH))  w_state_next = FQ_FULL;
    end

    assign o_dbg_state = r_state;

    always_comb begin
        out_valid   = !w_empty;
        out_pc      = '0;
        out_instrux = '0;
        if (!w_empty) begin
            out_pc      = w_head.pc;
            out_instrux = w_head.instrux;
        end
`ifdef FETCH_QUEUE_BYPASS_EN
        if (w_bypass) begin
            out_valid   = 1'b1;
            out_pc      = in_pc;
            out_instrux = in_instrux;
        end
`endif
    end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int DEPTH = 4;
  localparam int OW    = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic             in_valid;
  logic [63:0]      in_pc;
  logic [31:0]      in_instrux;
  logic             in_ready;
  logic             flush;
  logic             deq_stall;
  logic             out_valid;
  logic [63:0]      out_pc;
  logic [31:0]      out_instrux;
  logic [OW-1:0]    occupancy;
  fq_state_e        dbg_state;

  fetch_queue #(.DEPTH(DEPTH), .PC_WIDTH(64), .INSTR_WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_pc       (in_pc),
    .in_instrux  (in_instrux),
    .in_ready    (in_ready),
    .flush       (flush),
    .deq_stall   (deq_stall),
    .out_valid   (out_valid),
    .out_pc      (out_pc),
    .out_instrux (out_instrux),
    .occupancy   (occupancy),
    .o_dbg_state (dbg_state)
  );

  // ---------------- reference model ----------------
  // Queue contents in program order, each entry {pc, instrux}.
  logic [95:0] exp_q[$];
  int n_pass  = 0;
  int n_total = 0;

  function automatic logic exp_valid();
    if (exp_q.size() > 0) return 1'b1;
`ifdef FETCH_QUEUE_BYPASS_EN
    if (reset && in_valid && !flush) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic logic [95:0] exp_head();
    if (exp_q.size() > 0) return exp_q[0];
`ifdef FETCH_QUEUE_BYPASS_EN
    if (reset && in_valid && !flush) return {in_pc, in_instrux};
`endif
    return '0;
  endfunction

  function automatic fq_state_e exp_state();
    if (exp_q.size() == 0)     return FQ_EMPTY;
    if (exp_q.size() == DEPTH) return FQ_FULL;
    return FQ_PARTIAL;
  endfunction

  // Advance one clock. The model applies the queue rules to the inputs
  // present at the edge. Inputs may be changed again #1 after the edge.
  task automatic cycle();
    logic        do_enq;
    logic        do_deq;
    logic        do_byp;
    logic [95:0] word;
    do_byp = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
    do_byp = in_valid && exp_q.size() == 0 && !deq_stall;
`endif
    do_deq = exp_q.size() > 0 && !deq_stall;
    do_enq = in_valid && exp_q.size() < DEPTH && !do_byp;
    word   = {in_pc, in_instrux};
    @(posedge clk);
    if (!reset || flush) begin
      exp_q.delete();
    end else begin
      if (do_deq) void'(exp_q.pop_front());
      if (do_enq) exp_q.push_back(word);
    end
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [63:0] pc, input logic stall, input logic fl);
    in_valid   = v;
    in_pc      = pc;
    in_instrux = $urandom();
    deq_stall  = stall;
    flush      = fl;
  endtask

  task automatic clear_queue();
    drive(1'b0, 64'h0, 1'b0, 1'b1);
    cycle();
    flush = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0;
    drive(1'b1, 64'hDEAD_0000, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      cycle();
      @(negedge clk);
      n_total++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else n_pass++;
      n_total++; if (out_pc !== 64'h0) $display("FAIL reset_pc: got %h want 0", out_pc); else n_pass++;
      n_total++; if (in_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", in_ready); else n_pass++;
      n_total++; if (occupancy !== OW'(0)) $display("FAIL reset_occ: got %0d want 0", occupancy); else n_pass++;
    end
    @(posedge clk); #1;
    reset = 1'b1;
    drive(1'b0, 64'h0, 1'b0, 1'b0);
    @(negedge clk);
    n_total++; if (occupancy !== OW'(0)) $display("FAIL reset_after_occ: got %0d want 0", occupancy); else n_pass++;
    n_total++; if (dbg_state !== FQ_EMPTY) $display("FAIL reset_state: got %0d want %0d", dbg_state, FQ_EMPTY); else n_pass++;
    cycle();
  endtask

  task automatic test_fill();
    clear_queue();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 64'h1000 + 64'(4 * i), 1'b1, 1'b0);
      @(negedge clk);
      n_total++; if (in_ready !== 1'b1) $display("FAIL fill_ready[%0d]: got %b want 1", i, in_ready); else n_pass++;
      cycle();
    end
    drive(1'b1, 64'h1010, 1'b1, 1'b0);
    @(negedge clk);
    n_total++; if (occupancy !== OW'(DEPTH)) $display("FAIL fill_occ: got %0d want %0d", occupancy, DEPTH); else n_pass++;
    n_total++; if (in_ready !== 1'b0) $display("FAIL fill_full_ready: got %b want 0", in_ready); else n_pass++;
    n_total++; if (dbg_state !== FQ_FULL) $display("FAIL fill_state: got %0d want %0d", dbg_state, FQ_FULL); else n_pass++;
    cycle();
    drive(1'b0, 64'h0, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      n_total++;
      if (out_valid !== 1'b1 || out_pc !== 64'h1000 + 64'(4 * i))
        $display("FAIL fill_drain[%0d]: got v=%b pc=%h want v=1 pc=%h", i, out_valid, out_pc, 64'h1000 + 64'(4 * i));
      else n_pass++;
      cycle();
    end
    @(negedge clk);
    n_total++; if (out_valid !== 1'b0) $display("FAIL fill_empty: got %b want 0", out_valid); else n_pass++;
    n_total++; if (out_instrux !== 32'h0) $display("FAIL fill_bubble: got %h want 0", out_instrux); else n_pass++;
  endtask

  task automatic test_flush();
    clear_queue();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 64'h1800 + 64'(4 * i), 1'b1, 1'b0);
      cycle();
    end
    drive(1'b1, 64'h2000, 1'b1, 1'b1);
    @(negedge clk);
    n_total++; if (occupancy !== OW'(3)) $display("FAIL flush_pre_occ: got %0d want 3", occupancy); else n_pass++;
    cycle();
    drive(1'b0, 64'h0, 1'b1, 1'b0);
    @(negedge clk);
    n_total++; if (occupancy !== OW'(0)) $display("FAIL flush_occ: got %0d want 0", occupancy); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL flush_valid: got %b want 0", out_valid); else n_pass++;
    drive(1'b1, 64'h3000, 1'b1, 1'b0);
    cycle();
    drive(1'b0, 64'h0, 1'b1, 1'b0);
    @(negedge clk);
    n_total++;
    if (out_valid !== 1'b1 || out_pc !== 64'h3000 || occupancy !== OW'(1))
      $display("FAIL flush_refill: got v=%b pc=%h occ=%0d want v=1 pc=3000 occ=1", out_valid, out_pc, occupancy);
    else n_pass++;
    cycle();
  endtask

  task automatic test_wrap();
    logic [63:0] got[$];
    int sent;
    clear_queue();
    sent = 0;
    for (int cyc = 0; cyc < 100 && got.size() < 10; cyc++) begin
      drive(sent < 10, 64'h1000 + 64'(4 * sent), cyc[0], 1'b0);
      @(negedge clk);
      n_total++; if (out_valid !== exp_valid()) $display("FAIL wrap_valid[%0d]: got %b want %b", cyc, out_valid, exp_valid()); else n_pass++;
      if (out_valid && !deq_stall) got.push_back(out_pc);
      if (in_valid && in_ready) sent++;
      cycle();
    end
    n_total++; if (got.size() != 10) $display("FAIL wrap_count: got %0d want 10", got.size()); else n_pass++;
    for (int i = 0; i < got.size() && i < 10; i++) begin
      n_total++;
      if (got[i] !== 64'h1000 + 64'(4 * i)) $display("FAIL wrap_order[%0d]: got %h want %h", i, got[i], 64'h1000 + 64'(4 * i));
      else n_pass++;
    end
  endtask

  task automatic test_simultaneous();
    clear_queue();
    drive(1'b1, 64'h5000, 1'b1, 1'b0); cycle();
    drive(1'b1, 64'h5004, 1'b1, 1'b0); cycle();
    drive(1'b1, 64'h5008, 1'b0, 1'b0);
    @(negedge clk);
    n_total++; if (occupancy !== OW'(2) || out_pc !== 64'h5000) $display("FAIL simul_pre: got occ=%0d pc=%h want occ=2 pc=5000", occupancy, out_pc); else n_pass++;
    cycle();
    drive(1'b0, 64'h0, 1'b1, 1'b0);
    @(negedge clk);
    n_total++; if (occupancy !== OW'(2)) $display("FAIL simul_occ: got %0d want 2", occupancy); else n_pass++;
    n_total++; if (out_pc !== 64'h5004) $display("FAIL simul_head: got %h want 5004", out_pc); else n_pass++;
    cycle();
  endtask

`ifdef FETCH_QUEUE_BYPASS_EN
  task automatic test_bypass();
    clear_queue();
    drive(1'b1, 64'h4000, 1'b0, 1'b0);
    @(negedge clk);
    n_total++; if (out_valid !== 1'b1 || out_pc !== 64'h4000) $display("FAIL bypass_out: got v=%b pc=%h want v=1 pc=4000", out_valid, out_pc); else n_pass++;
    n_total++; if (occupancy !== OW'(0)) $display("FAIL bypass_occ_now: got %0d want 0", occupancy); else n_pass++;
    cycle();
    drive(1'b0, 64'h0, 1'b0, 1'b0);
    @(negedge clk);
    n_total++; if (occupancy !== OW'(0) || out_valid !== 1'b0) $display("FAIL bypass_after: got occ=%0d v=%b want occ=0 v=0", occupancy, out_valid); else n_pass++;
  endtask
`endif

  task automatic test_random();
    logic [95:0] h;
    for (int cyc = 0; cyc < 400; cyc++) begin
      drive($urandom_range(0, 9) < 7, {$urandom(), $urandom()}, $urandom_range(0, 9) < 4, $urandom_range(0, 19) == 0);
      reset = ($urandom_range(0, 99) != 0);
      @(negedge clk);
      h = exp_head();
      n_total++; if (out_valid !== exp_valid()) $display("FAIL rand_valid[%0d]: got %b want %b", cyc, out_valid, exp_valid()); else n_pass++;
      n_total++; if (out_pc !== h[95:32]) $display("FAIL rand_pc[%0d]: got %h want %h", cyc, out_pc, h[95:32]); else n_pass++;
      n_total++; if (out_instrux !== h[31:0]) $display("FAIL rand_instr[%0d]: got %h want %h", cyc, out_instrux, h[31:0]); else n_pass++;
      n_total++; if (occupancy !== OW'(exp_q.size())) $display("FAIL rand_occ[%0d]: got %0d want %0d", cyc, occupancy, exp_q.size()); else n_pass++;
      n_total++; if (in_ready !== (exp_q.size() < DEPTH)) $display("FAIL rand_ready[%0d]: got %b want %b", cyc, in_ready, exp_q.size() < DEPTH); else n_pass++;
      n_total++; if (dbg_state !== exp_state()) $display("FAIL rand_state[%0d]: got %0d want %0d", cyc, dbg_state, exp_state()); else n_pass++;
      cycle();
    end
    reset = 1'b1;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    reset = 1'b0;
    drive(1'b0, 64'h0, 1'b0, 1'b0);
    test_reset();
    test_fill();
    test_flush();
    test_wrap();
    test_simultaneous();
`ifdef FETCH_QUEUE_BYPASS_EN
    test_bypass();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
